// File: rtl/pic_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg : shared OCW2 command encodings, resolver FSM states, level helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pic_pkg;

  localparam int LVL_W = 3;

  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRIO     = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_ACK1 = 2'd2,
    ST_ACK2 = 2'd3
  } pic_state_e;

  // 0 = highest priority, 7 = lowest, relative to the rotating pointer
  function automatic logic [LVL_W-1:0] prio_rank(input logic [LVL_W-1:0] idx,
                                                 input logic [LVL_W-1:0] lowest);
    return idx - lowest - 3'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rot_prio_enc.sv
// ---------------------------------------------------------------------------
// rot_prio_enc : rotating-priority encoder, highest priority at lowest_i+1
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module rot_prio_enc
  import pic_pkg::*;
(
  input  logic [7:0]       vec_i,
  input  logic [LVL_W-1:0] lowest_i,
  output logic             valid_o,
  output logic [LVL_W-1:0] idx_o
);

  // Scan from lowest to highest priority so the last hit wins
  always_comb begin
    valid_o = |vec_i;
    idx_o   = '0;
    for (int k = 7; k >= 0; k--) begin
      if (vec_i[lowest_i + 3'(k + 1)]) begin
        idx_o = lowest_i + 3'(k + 1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/int_priority_resolver.sv
// ---------------------------------------------------------------------------
// int_priority_resolver : 8259-style IRR/ISR, rotating priority, INTA sequencing
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module int_priority_resolver
  import pic_pkg::*;
#(
  parameter int NUM_IR = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IR-1:0] ir,
  input  logic              ltim,
  input  logic [NUM_IR-1:0] mask_reg,
  input  logic [2:0]        r_sl_eoi,
  input  logic [LVL_W-1:0]  ocw2_level,
  input  logic              ocw2_stb,
  input  logic              aeoi,
  input  logic [4:0]        vector_base,
  input  logic              ack1_stb,
  input  logic              ack2_stb,
  input  logic              ack2_end,
  output logic              intreq,
  output logic [NUM_IR-1:0] irr,
  output logic [NUM_IR-1:0] isr,
  output logic [7:0]        vector,
  output logic              vector_valid
);

  pic_state_e        state_q;
  logic [NUM_IR-1:0] irr_q, irr_d, isr_q, isr_d, ir_hist_q;
  logic [LVL_W-1:0]  prio_q, prio_d, level_q;
  logic              rot_q, rot_d, spur_q, intreq_q, intreq_d;
  logic [7:0]        vector_q;
  logic              vvalid_q;

  logic              cand_valid, isr_valid;
  logic [LVL_W-1:0]  cand_idx, isr_top;
  logic              ack1_take, end_take;

  rot_prio_enc u_cand_enc (
    .vec_i    (irr_q & ~mask_reg),
    .lowest_i (prio_q),
    .valid_o  (cand_valid),
    .idx_o    (cand_idx)
  );

  rot_prio_enc u_isr_enc (
    .vec_i    (isr_q),
    .lowest_i (prio_q),
    .valid_o  (isr_valid),
    .idx_o    (isr_top)
  );

  assign ack1_take = ack1_stb && (state_q == ST_REQ);
  assign end_take  = ack2_end && (state_q == ST_ACK2);

  // Order matters: EOI acts on pre-update ISR, then the ack1 set/clear wins
  always_comb begin
    irr_d    = ltim ? ir : (irr_q | (ir & ~ir_hist_q));
    isr_d    = isr_q;
    prio_d   = prio_q;
    rot_d    = rot_q;
    if (end_take && aeoi && !spur_q) begin
      isr_d[level_q] = 1'b0;
      if (rot_q) prio_d = level_q;
    end
    if (ocw2_stb) begin
      case (r_sl_eoi)
        OCW2_NS_EOI:       if (isr_valid) isr_d[isr_top] = 1'b0;
        OCW2_SP_EOI:       isr_d[ocw2_level] = 1'b0;
        OCW2_ROT_NS_EOI:   if (isr_valid) begin
                             isr_d[isr_top] = 1'b0;
                             prio_d         = isr_top;
                           end
        OCW2_ROT_SP_EOI:   begin
                             isr_d[ocw2_level] = 1'b0;
                             prio_d            = ocw2_level;
                           end
        OCW2_SET_PRIO:     prio_d = ocw2_level;
        OCW2_ROT_AEOI_SET: rot_d = 1'b1;
        OCW2_ROT_AEOI_CLR: rot_d = 1'b0;
        default:           ;
      endcase
    end
    if (ack1_take && cand_valid) begin
      isr_d[cand_idx] = 1'b1;
      irr_d[cand_idx] = 1'b0;
    end
    intreq_d = cand_valid &&
               (!isr_valid || (prio_rank(cand_idx, prio_q) < prio_rank(isr_top, prio_q)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irr_q     <= '0;
      isr_q     <= '0;
      ir_hist_q <= '0;
      prio_q    <= 3'd7;
      rot_q     <= 1'b0;
      intreq_q  <= 1'b0;
    end else begin
      irr_q     <= irr_d;
      isr_q     <= isr_d;
      ir_hist_q <= ir;
      prio_q    <= prio_d;
      rot_q     <= rot_d;
      intreq_q  <= intreq_d;
    end
  end

  // Acknowledge sequencer; a missing candidate at ack1 yields spurious level 7
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      level_q  <= '0;
      spur_q   <= 1'b0;
      vector_q <= '0;
      vvalid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (intreq_q) state_q <= ST_REQ;
        ST_REQ: begin
          if (ack1_stb) begin
            state_q <= ST_ACK1;
            level_q <= cand_valid ? cand_idx : 3'd7;
            spur_q  <= !cand_valid;
          end else if (!cand_valid) begin
            state_q <= ST_IDLE;
          end
        end
        ST_ACK1: if (ack2_stb) begin
          state_q  <= ST_ACK2;
          vector_q <= {vector_base, level_q};
          vvalid_q <= 1'b1;
        end
        ST_ACK2: if (ack2_end) begin
          state_q  <= ST_IDLE;
          vector_q <= '0;
          vvalid_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign intreq       = intreq_q;
  assign irr          = irr_q;
  assign isr          = isr_q;
  assign vector       = vector_q;
  assign vector_valid = vvalid_q;

endmodule

`default_nettype wire
